bk_save_ctrl: RTL

BK_SAVE_CTRL -- requirements
Module: bk_save_ctrl

---
 rtl/bk_save_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bk_save_ctrl.sv
// Backup-RAM save/load sequencer: walks sectors 0..last LBA through the HPS sd_rd/sd_wr handshake.
// Optional autosave on OSD open after a BSRAM write: define BK_SAVE_CTRL_AUTOSAVE_EN.
module bk_save_ctrl #(
    parameter logic [23:0] ACK_TIMEOUT  = 24'd10000000,
    parameter int          SECTOR_SHIFT = 9
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [23:0] ram_mask,
    input  logic        rom_dl,
    input  logic        img_mounted,
    input  logic        img_size_nz,
    input  logic        img_readonly,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        sd_ack,
    input  logic        bsram_we,
    input  logic        osd_open,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        bk_ena,
    output logic        bk_loading,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

    state_t      state_q;
    logic        armed_q, rom_dl_q, load_q, save_q, ack_q;
    logic        dir_q;
    logic [23:0] tmr_q;
    logic [31:0] lba_q;
    logic        rd_q, wr_q, bk_ena_q, loading_q, busy_q, err_q;

    logic        rom_rise, rom_fall, load_rise, save_rise, ack_rise, ack_fall;
    logic        auto_save, start_load, start_save;
    logic [31:0] last_lba;

    // armed_q masks edges on the first cycle after reset while the edge registers reload
    assign rom_rise  = armed_q &  rom_dl   & ~rom_dl_q;
    assign rom_fall  = armed_q & ~rom_dl   &  rom_dl_q;
    assign load_rise = armed_q &  load_req & ~load_q;
    assign save_rise = armed_q &  save_req & ~save_q;
    assign ack_rise  = armed_q &  sd_ack   & ~ack_q;
    assign ack_fall  = armed_q & ~sd_ack   &  ack_q;

    assign last_lba   = 32'(ram_mask[23:SECTOR_SHIFT]);
    assign start_load = bk_ena_q & (load_rise | rom_fall);
    assign start_save = bk_ena_q & (save_rise | auto_save) & ~start_load;

`ifdef BK_SAVE_CTRL_AUTOSAVE_EN
    logic dirty_q, osd_q;

    assign auto_save = armed_q & osd_open & ~osd_q & dirty_q;

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            dirty_q <= 1'b0;
            osd_q   <= 1'b0;
        end else begin
            osd_q <= osd_open;
            if (state_q == S_IDLE && start_save && !rom_rise)
                dirty_q <= 1'b0;
            else if (bsram_we && bk_ena_q && !loading_q)
                dirty_q <= 1'b1;
        end
    end
`else
    logic unused_autosave;

    assign auto_save       = 1'b0;
    assign unused_autosave = bsram_we ^ osd_open;
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            rom_dl_q  <= 1'b0;
            load_q    <= 1'b0;
            save_q    <= 1'b0;
            ack_q     <= 1'b0;
            dir_q     <= 1'b0;
            tmr_q     <= '0;
            lba_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            bk_ena_q  <= 1'b0;
            loading_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            armed_q  <= 1'b1;
            rom_dl_q <= rom_dl;
            load_q   <= load_req;
            save_q   <= save_req;
            ack_q    <= sd_ack;
            err_q    <= 1'b0;

            // a mount reported during the download overrides the clear from its rising edge
            if (rom_rise)
                bk_ena_q <= 1'b0;
            if (rom_dl && img_mounted && img_size_nz && !img_readonly)
                bk_ena_q <= |ram_mask;

            case (state_q)
                S_IDLE: begin
                    if ((start_load || start_save) && !rom_rise) begin
                        state_q   <= S_REQ;
                        busy_q    <= 1'b1;
                        lba_q     <= '0;
                        dir_q     <= start_save;
                        rd_q      <= start_load;
                        wr_q      <= start_save;
                        loading_q <= start_load;
                        tmr_q     <= ACK_TIMEOUT - 24'd1;
                    end
                end
                S_REQ, S_XFER: begin
                    if (rom_rise) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        loading_q <= 1'b0;
                    end else if (state_q == S_REQ && ack_rise) begin
                        state_q <= S_XFER;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        tmr_q   <= ACK_TIMEOUT - 24'd1;
                    end else if (state_q == S_XFER && ack_fall) begin
                        if (lba_q >= last_lba) begin
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                            loading_q <= 1'b0;
                        end else begin
                            state_q <= S_REQ;
                            lba_q   <= lba_q + 32'd1;
                            rd_q    <= ~dir_q;
                            wr_q    <= dir_q;
                            tmr_q   <= ACK_TIMEOUT - 24'd1;
                        end
                    end else if (tmr_q == 24'd0) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        loading_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - 24'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sd_lba     = lba_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_ena     = bk_ena_q;
    assign bk_loading = loading_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule
